// File: rtl/hazard_sched.sv
// hazard_sched: stall/bubble/flush/forwarding control for the 5-stage RV32I pipeline,
// plus a data-memory wait FSM (IDLE/MEM_WAIT/ERROR) with a timeout watchdog.
// Latency: all controls are combinational from current state and stage inputs; state moves on clock.
// Backpressure: a memory wait or timeout error freezes every stage; load-use holds only IF/ID and
// injects a bubble into EX.
// Ports: clock/reset_n (async active-low); io_id_*/io_ex_*/io_mem_*/io_wb_* decoder results per stage;
// io_redirect taken branch/jump from EX; io_dmem_req/io_dmem_ready memory handshake;
// io_stall_*/io_bubble_ex/io_flush_id pipeline controls; io_fwd_a/b operand source (0 RF, 1 MEM, 2 WB);
// io_mem_err sticky timeout flag.
// Optional macro HAZARD_PERF_CNT_EN adds io_cnt_loaduse/io_cnt_memwait/io_cnt_flush (32-bit, wrapping).
module hazard_sched #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       io_id_valid,
    input  logic [4:0] io_id_rs1,
    input  logic [4:0] io_id_rs2,
    input  logic       io_id_use_rs1,
    input  logic       io_id_use_rs2,
    input  logic       io_ex_valid,
    input  logic [4:0] io_ex_rd,
    input  logic       io_ex_regwrite,
    input  logic       io_ex_memread,
    input  logic       io_mem_valid,
    input  logic [4:0] io_mem_rd,
    input  logic       io_mem_regwrite,
    input  logic       io_wb_valid,
    input  logic [4:0] io_wb_rd,
    input  logic       io_wb_regwrite,
    input  logic       io_redirect,
    input  logic       io_dmem_req,
    input  logic       io_dmem_ready,
    output logic       io_stall_if,
    output logic       io_stall_id,
    output logic       io_stall_ex,
    output logic       io_stall_mem,
    output logic       io_bubble_ex,
    output logic       io_flush_id,
    output logic [1:0] io_fwd_a,
    output logic [1:0] io_fwd_b,
    output logic       io_mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] io_cnt_loaduse,
    output logic [31:0] io_cnt_memwait,
    output logic [31:0] io_cnt_flush
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

    localparam logic [3:0]  FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);
    localparam bit          TIMEOUT_EN   = (MEM_TIMEOUT != 0);

    state_e      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;

    logic in_err;
    logic mem_block;
    logic live;
    logic flush_busy;
    logic ld_hazard;
    logic load_use;

    function automatic logic stage_hit(input logic vld, input logic wr,
                                       input logic [4:0] rd, input logic [4:0] r);
        return vld && wr && (rd != 5'd0) && (rd == r);
    endfunction

    // mem_block covers both the cycle the wait is discovered (still IDLE) and
    // every MEM_WAIT cycle until ready; the exit cycle is treated as a normal
    // IDLE cycle so a redirect frozen in EX gets acted on before EX advances.
    assign in_err     = (state_q == ST_ERROR);
    assign mem_block  = ((state_q == ST_MEM_WAIT) || ((state_q == ST_IDLE) && io_dmem_req))
                        && !io_dmem_ready;
    assign live       = !in_err && !mem_block;
    assign flush_busy = (flush_cnt_q != 4'd0);
    assign ld_hazard  = io_id_valid && io_ex_valid && io_ex_memread && io_ex_regwrite &&
                        (io_ex_rd != 5'd0) &&
                        ((io_id_use_rs1 && (io_id_rs1 == io_ex_rd)) ||
                         (io_id_use_rs2 && (io_id_rs2 == io_ex_rd)));
    // The ID instruction is wrong-path while a flush is pending, so no load-use.
    assign load_use   = live && !io_redirect && !flush_busy && ld_hazard;

    assign io_stall_ex  = in_err || mem_block;
    assign io_stall_mem = in_err || mem_block;
    assign io_stall_if  = in_err || mem_block || load_use;
    assign io_stall_id  = in_err || mem_block || load_use;
    assign io_bubble_ex = (live && io_redirect) || load_use;
    assign io_flush_id  = live && (io_redirect || flush_busy);
    assign io_mem_err   = in_err;

    always_comb begin
        io_fwd_a = 2'd0;
        io_fwd_b = 2'd0;
        if (io_id_use_rs1 && stage_hit(io_mem_valid, io_mem_regwrite, io_mem_rd, io_id_rs1)) begin
            io_fwd_a = 2'd1;
        end else if (io_id_use_rs1 && stage_hit(io_wb_valid, io_wb_regwrite, io_wb_rd, io_id_rs1)) begin
            io_fwd_a = 2'd2;
        end
        if (io_id_use_rs2 && stage_hit(io_mem_valid, io_mem_regwrite, io_mem_rd, io_id_rs2)) begin
            io_fwd_b = 2'd1;
        end else if (io_id_use_rs2 && stage_hit(io_wb_valid, io_wb_regwrite, io_wb_rd, io_id_rs2)) begin
            io_fwd_b = 2'd2;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        flush_cnt_d = flush_cnt_q;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = 16'd0;
                if (io_dmem_req && !io_dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (io_dmem_ready) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 16'd0;
                end else begin
                    if (wait_cnt_q != 16'hFFFF) begin
                        wait_cnt_d = wait_cnt_q + 16'd1;
                    end
                    if (TIMEOUT_EN && (wait_cnt_q == TIMEOUT_LAST)) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Fetch is frozen along with everything else during a memory wait,
        // so the flush countdown pauses rather than expiring unseen.
        if (live) begin
            if (io_redirect) begin
                flush_cnt_d = FLUSH_LOAD;
            end else if (flush_busy) begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= 4'd0;
            wait_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] cnt_loaduse_q, cnt_loaduse_d;
    logic [31:0] cnt_memwait_q, cnt_memwait_d;
    logic [31:0] cnt_flush_q, cnt_flush_d;

    always_comb begin
        cnt_loaduse_d = cnt_loaduse_q + {31'd0, load_use};
        cnt_memwait_d = cnt_memwait_q + {31'd0, (state_q == ST_MEM_WAIT)};
        cnt_flush_d   = cnt_flush_q + {31'd0, io_flush_id};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_loaduse_q <= 32'd0;
            cnt_memwait_q <= 32'd0;
            cnt_flush_q   <= 32'd0;
        end else begin
            cnt_loaduse_q <= cnt_loaduse_d;
            cnt_memwait_q <= cnt_memwait_d;
            cnt_flush_q   <= cnt_flush_d;
        end
    end

    assign io_cnt_loaduse = cnt_loaduse_q;
    assign io_cnt_memwait = cnt_memwait_q;
    assign io_cnt_flush   = cnt_flush_q;
`endif

endmodule
